// File: rtl/sync_ram_err.sv
// Single-port synchronous RAM with registered read, per-entry valid bits and
// fault reporting (out-of-range, read/write collision, uninitialised read).
module sync_ram_err #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RANGE = 2'b01;
    localparam logic [1:0] CODE_COLL  = 2'b10;
    localparam logic [1:0] CODE_UNINI = 2'b11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              mem_we_s;
    logic              in_range_s;
    logic [IDX_W-1:0]  idx_s;

    assign in_range_s = ({1'b0, addr} < DEPTH_EXT);
    assign idx_s      = addr[IDX_W-1:0];

    // Request decode in fault-priority order, plus next-state for bookkeeping.
    always_comb begin
        mem_we_s     = 1'b0;
        valid_d      = valid_q;
        r_data_d     = r_data_q;
        r_valid_d    = 1'b0;
        error_d      = 1'b0;
        err_code_d   = CODE_NONE;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (!(wen || ren)) begin
            error_d = 1'b0;
        end else if (!in_range_s) begin
            error_d    = 1'b1;
            err_code_d = CODE_RANGE;
        end else if (wen && ren) begin
            mem_we_s       = 1'b1;
            valid_d[idx_s] = 1'b1;
            error_d        = 1'b1;
            err_code_d     = CODE_COLL;
        end else if (wen) begin
            mem_we_s       = 1'b1;
            valid_d[idx_s] = 1'b1;
        end else if (valid_q[idx_s]) begin
            r_data_d  = mem_q[idx_s];
            r_valid_d = 1'b1;
        end else begin
            r_data_d   = {DATA_W{1'b0}};
            r_valid_d  = 1'b1;
            error_d    = 1'b1;
            err_code_d = CODE_UNINI;
        end

        // A fault in the same cycle as err_clr restarts the count at one.
        if (error_d) begin
            err_sticky_d = 1'b1;
            err_count_d  = err_clr ? {{(CNT_W-1){1'b0}}, 1'b1} : sat_inc(err_count_q);
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = {CNT_W{1'b0}};
        end else begin
            err_sticky_d = err_sticky_q;
            err_count_d  = err_count_q;
        end
    end

    // Storage array; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= w_data;
        end
    end

    // Valid bits, registered read response and fault state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= {DEPTH{1'b0}};
            r_data_q     <= {DATA_W{1'b0}};
            r_valid_q    <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= CODE_NONE;
            err_sticky_q <= 1'b0;
            err_count_q  <= {CNT_W{1'b0}};
        end else begin
            valid_q      <= valid_d;
            r_data_q     <= r_data_d;
            r_valid_q    <= r_valid_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign r_data     = r_data_q;
    assign r_valid    = r_valid_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_sync_ram_err.sv
// Directed scoreboard bench for sync_ram_err (DATA_W=4, DEPTH=8, ADDR_W=4, CNT_W=8).
module tb_sync_ram_err;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic       ren;
    logic [3:0] addr;
    logic [3:0] w_data;
    logic       err_clr;
    logic [3:0] r_data;
    logic       r_valid;
    logic       error;
    logic [1:0] err_code;
    logic       err_sticky;
    logic [7:0] err_count;

    sync_ram_err #(.DATA_W(4), .DEPTH(8), .ADDR_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .addr(addr),
        .w_data(w_data), .err_clr(err_clr), .r_data(r_data), .r_valid(r_valid),
        .error(error), .err_code(err_code), .err_sticky(err_sticky),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [3:0] rd;
        logic       er;
        logic [1:0] ec;
        logic [7:0] cnt;
        logic       st;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_mem [8];
    logic [7:0] m_vld;
    logic [3:0] m_rd;
    logic [7:0] m_cnt;
    logic       m_st;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".r_valid"}, 32'(r_valid), 32'(e.rv));
            chk({tag, ".r_data"}, 32'(r_data), 32'(e.rd));
            chk({tag, ".error"}, 32'(error), 32'(e.er));
            chk({tag, ".err_code"}, 32'(err_code), 32'(e.ec));
            chk({tag, ".err_count"}, 32'(err_count), 32'(e.cnt));
            chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(e.st));
        end
    endtask

    // Model one request, push its expected response, clock it in and compare.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [3:0] a, input logic [3:0] d, input logic clr);
        exp_t e;
        e.rv = 1'b0;
        e.er = 1'b0;
        e.ec = 2'b00;
        if (w || r) begin
            if (a >= 4'd8) begin
                e.er = 1'b1;
                e.ec = 2'b01;
            end else if (w && r) begin
                m_mem[a[2:0]] = d;
                m_vld[a[2:0]] = 1'b1;
                e.er = 1'b1;
                e.ec = 2'b10;
            end else if (w) begin
                m_mem[a[2:0]] = d;
                m_vld[a[2:0]] = 1'b1;
            end else begin
                e.rv = 1'b1;
                if (m_vld[a[2:0]]) begin
                    m_rd = m_mem[a[2:0]];
                end else begin
                    m_rd = 4'h0;
                    e.er = 1'b1;
                    e.ec = 2'b11;
                end
            end
        end
        if (e.er) begin
            m_st  = 1'b1;
            m_cnt = clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
        end else if (clr) begin
            m_st  = 1'b0;
            m_cnt = 8'd0;
        end
        e.rd  = m_rd;
        e.cnt = m_cnt;
        e.st  = m_st;
        sb.push_back(e);
        wen     = w;
        ren     = r;
        addr    = a;
        w_data  = d;
        err_clr = clr;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic model_reset();
        m_vld = 8'h00;
        m_rd  = 4'h0;
        m_cnt = 8'd0;
        m_st  = 1'b0;
        sb.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n   = 1'b0;
        wen     = 1'b0;
        ren     = 1'b0;
        addr    = 4'h0;
        w_data  = 4'h0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.r_data", 32'(r_data), 32'h0);
        chk("reset.r_valid", 32'(r_valid), 32'h0);
        chk("reset.error", 32'(error), 32'h0);
        chk("reset.err_code", 32'(err_code), 32'h0);
        chk("reset.err_sticky", 32'(err_sticky), 32'h0);
        chk("reset.err_count", 32'(err_count), 32'h0);
        rst_n = 1'b1;

        // Uninitialised read after reset.
        step("uninit_rd3", 1'b0, 1'b1, 4'd3, 4'h0, 1'b0);
        chk("uninit_rd3.code_lit", 32'(err_code), 32'h3);
        chk("uninit_rd3.count_lit", 32'(err_count), 32'h1);

        // Write then read back next cycle.
        step("wr5", 1'b1, 1'b0, 4'd5, 4'hA, 1'b0);
        step("rd5", 1'b0, 1'b1, 4'd5, 4'h0, 1'b0);
        chk("rd5.data_lit", 32'(r_data), 32'hA);

        // Fill every entry back-to-back, then read all in order.
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 4'(i), 4'(i + 1), 1'b0);
        for (int i = 0; i < 8; i++) step("readback", 1'b0, 1'b1, 4'(i), 4'h0, 1'b0);

        // Idle with err_clr, then out-of-range write and read.
        step("clr_idle", 1'b0, 1'b0, 4'd0, 4'h0, 1'b1);
        step("idle", 1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        step("oor_wr9", 1'b1, 1'b0, 4'd9, 4'hF, 1'b0);
        step("oor_rd12", 1'b0, 1'b1, 4'd12, 4'h0, 1'b0);
        chk("oor.count_lit", 32'(err_count), 32'h2);
        step("reread1", 1'b0, 1'b1, 4'd1, 4'h0, 1'b0);
        chk("reread1.data_lit", 32'(r_data), 32'h2);

        // Collision: write wins, read suppressed.
        step("coll2", 1'b1, 1'b1, 4'd2, 4'h7, 1'b0);
        step("rd2", 1'b0, 1'b1, 4'd2, 4'h0, 1'b0);
        chk("rd2.data_lit", 32'(r_data), 32'h7);

        // Counter saturation and err_clr interactions.
        for (int i = 0; i < 300; i++) step("sat", 1'b0, 1'b1, 4'd15, 4'h0, 1'b0);
        chk("sat.count_lit", 32'(err_count), 32'hFF);
        step("clr_alone", 1'b0, 1'b0, 4'd0, 4'h0, 1'b1);
        chk("clr_alone.count_lit", 32'(err_count), 32'h0);
        step("clr_fault", 1'b1, 1'b0, 4'd8, 4'h1, 1'b1);
        chk("clr_fault.count_lit", 32'(err_count), 32'h1);
        chk("clr_fault.sticky_lit", 32'(err_sticky), 32'h1);

        // Mid-stream reset with a read in flight.
        step("wr0", 1'b1, 1'b0, 4'd0, 4'h3, 1'b0);
        step("rd0", 1'b0, 1'b1, 4'd0, 4'h0, 1'b0);
        wen = 1'b0;
        ren = 1'b1;
        addr = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.r_data", 32'(r_data), 32'h0);
        chk("async_rst.r_valid", 32'(r_valid), 32'h0);
        chk("async_rst.err_sticky", 32'(err_sticky), 32'h0);
        chk("async_rst.err_count", 32'(err_count), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold.r_valid", 32'(r_valid), 32'h0);
        chk("rst_hold.error", 32'(error), 32'h0);
        ren = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step("post_rst_idle", 1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        step("post_rst_rd0", 1'b0, 1'b1, 4'd0, 4'h0, 1'b0);
        chk("post_rst_rd0.code_lit", 32'(err_code), 32'h3);
        chk("post_rst_rd0.data_lit", 32'(r_data), 32'h0);

        wen = 1'b0;
        ren = 1'b0;
        err_clr = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
